alu_seq: RTL and testbench

Multi-cycle integer execute unit that sits directly downstream of the ALU-control decoder. It consumes the 4-bit operation code and two register/immediate operands and returns a registered result plus a branch-taken flag. It uses a valid/ready handshake on input and a one-cycle `valid_out` pulse on output. Logic ops complete in one cycle; shifts are iterative, one bit per cycle, so no barrel shifter is needed.

---
 rtl/alu_ops_pkg.sv | 27 ++
 rtl/alu_cmp.sv | 16 +
 rtl/alu_seq.sv | 118 +++++++++++
 tb/tb_alu_seq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ops_pkg.sv
// Op-code encoding shared with the ALU-control decoder, plus small decode helpers.
package alu_ops_pkg;

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpSll  = 4'd5;
  localparam logic [3:0] OpSrl  = 4'd6;
  localparam logic [3:0] OpSlt  = 4'd7;
  localparam logic [3:0] OpBeq  = 4'd8;
  localparam logic [3:0] OpBne  = 4'd9;
  localparam logic [3:0] OpBlt  = 4'd10;
  localparam logic [3:0] OpBge  = 4'd11;
  localparam logic [3:0] OpBltu = 4'd12;
  localparam logic [3:0] OpBgeu = 4'd13;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OpSll) || (op == OpSrl);
  endfunction

  function automatic logic is_branch(input logic [3:0] op);
    return (op >= OpBeq) && (op <= OpBgeu);
  endfunction

endpackage

// File: rtl/alu_cmp.sv
// Combinational comparator shared by SLT and the branch op codes.
module alu_cmp #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             lt,
  output logic             ltu
);

  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle execute unit: single-cycle logic/arith/compare, bit-serial shifts,
// valid/ready request handshake and a one-cycle valid_out result pulse.
module alu_seq
  import alu_ops_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [3:0]       ALU_ctr,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             valid_out,
  output logic [WIDTH-1:0] result,
  output logic             branch_taken
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] result_q;
  logic             branch_q;
  logic [WIDTH-1:0] work_q;
  logic [SHW-1:0]   cnt_q;
  logic             dir_left_q;

  logic [WIDTH-1:0] alu_res;
  logic             alu_br;
  logic [WIDTH-1:0] work_shifted;
  logic [SHW-1:0]   shamt;
  logic             cmp_eq, cmp_lt, cmp_ltu;

  alu_cmp #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .a  (src_a),
    .b  (src_b),
    .eq (cmp_eq),
    .lt (cmp_lt),
    .ltu(cmp_ltu)
  );

  assign shamt        = src_b[SHW-1:0];
  assign work_shifted = dir_left_q ? (work_q << 1) : (work_q >> 1);

  // Single-cycle result; shifts land here only for the shamt == 0 case.
  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    case (ALU_ctr)
      OpAdd:        alu_res = src_a + src_b;
      OpSub:        alu_res = src_a - src_b;
      OpAnd:        alu_res = src_a & src_b;
      OpOr:         alu_res = src_a | src_b;
      OpXor:        alu_res = src_a ^ src_b;
      OpSll, OpSrl: alu_res = src_a;
      OpSlt:        alu_res = {{(WIDTH-1){1'b0}}, cmp_lt};
      OpBeq:        alu_br  = cmp_eq;
      OpBne:        alu_br  = ~cmp_eq;
      OpBlt:        alu_br  = cmp_lt;
      OpBge:        alu_br  = ~cmp_lt;
      OpBltu:       alu_br  = cmp_ltu;
      OpBgeu:       alu_br  = ~cmp_ltu;
      default:      ;
    endcase
    if (is_branch(ALU_ctr)) begin
      alu_res = {{(WIDTH-1){1'b0}}, alu_br};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      result_q   <= '0;
      branch_q   <= 1'b0;
      work_q     <= '0;
      cnt_q      <= '0;
      dir_left_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (valid_in) begin
            if (is_shift(ALU_ctr) && (shamt != '0)) begin
              work_q     <= src_a;
              cnt_q      <= shamt;
              dir_left_q <= (ALU_ctr == OpSll);
              state_q    <= StShift;
            end else begin
              result_q <= alu_res;
              branch_q <= alu_br;
              state_q  <= StDone;
            end
          end
        end
        StShift: begin
          work_q <= work_shifted;
          cnt_q  <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            result_q <= work_shifted;
            branch_q <= 1'b0;
            state_q  <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready_out    = (state_q == StIdle);
  assign valid_out    = (state_q == StDone);
  assign result       = result_q;
  assign branch_taken = branch_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vectors, randomized ops against a
// behavioural model, held-request back-to-back behaviour and reset mid-shift.
module tb_alu_seq;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic          ready_out;
  logic [3:0]    ALU_ctr;
  logic [W-1:0]  src_a;
  logic [W-1:0]  src_b;
  logic          valid_out;
  logic [W-1:0]  result;
  logic          branch_taken;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(
    .WIDTH(W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .ALU_ctr     (ALU_ctr),
    .src_a       (src_a),
    .src_b       (src_b),
    .valid_out   (valid_out),
    .result      (result),
    .branch_taken(branch_taken)
  );

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        br;
    logic [7:0]  lat;
  } vec_t;

  // Reference model: result, branch flag and accept-to-valid_out latency.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic br, output int lat);
    int          sa, sb;
    int unsigned sh;
    sa  = a;
    sb  = b;
    sh  = b % 32;
    r   = '0;
    br  = 1'b0;
    lat = 1;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  begin r = a << sh; lat = (sh == 0) ? 1 : int'(sh) + 1; end
      4'd6:  begin r = a >> sh; lat = (sh == 0) ? 1 : int'(sh) + 1; end
      4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd8:  br = (a == b);
      4'd9:  br = (a != b);
      4'd10: br = (sa < sb);
      4'd11: br = (sa >= sb);
      4'd12: br = (a < b);
      4'd13: br = (a >= b);
      default: ;
    endcase
    if (op >= 4'd8 && op <= 4'd13) r = {31'b0, br};
  endfunction

  // Issue one op from IDLE; returns observations at the valid_out cycle (bounded wait).
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic br, output int lat,
                        output logic rdy_low);
    @(negedge clk);
    valid_in = 1'b1;
    ALU_ctr  = op;
    src_a    = a;
    src_b    = b;
    lat      = 0;
    rdy_low  = 1'b1;
    r        = '0;
    br       = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
      ALU_ctr  = 4'($urandom);
      src_a    = $urandom;
      src_b    = $urandom;
      lat++;
      if (ready_out) rdy_low = 1'b0;
      if (valid_out) begin
        r  = result;
        br = branch_taken;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    valid_in = 1'b0;
    ALU_ctr  = '0;
    src_a    = '0;
    src_b    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (ready_out !== 1'b1 || valid_out !== 1'b0 || result !== '0 || branch_taken !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b result=%h br=%b, required 1 0 0 0",
               ready_out, valid_out, result, branch_taken);
    end
  endtask

  task automatic test_directed();
    vec_t        vq[$];
    logic [31:0] r;
    logic        br, rl;
    int          lat;
    vq.push_back('{4'd0,  32'hFFFF_FFFF, 32'd1,        32'h0000_0000, 1'b0, 8'd1});
    vq.push_back('{4'd1,  32'd5,         32'd7,        32'hFFFF_FFFE, 1'b0, 8'd1});
    vq.push_back('{4'd7,  32'h8000_0000, 32'd1,        32'd1,         1'b0, 8'd1});
    vq.push_back('{4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 8'd1});
    vq.push_back('{4'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 8'd1});
    vq.push_back('{4'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 8'd1});
    vq.push_back('{4'd5,  32'd1,         32'd31,       32'h8000_0000, 1'b0, 8'd32});
    vq.push_back('{4'd6,  32'hDEAD_BEEF, 32'd0,        32'hDEAD_BEEF, 1'b0, 8'd1});
    vq.push_back('{4'd6,  32'hDEAD_BEEF, 32'h0000_0024, 32'h0DEA_DBEE, 1'b0, 8'd5});
    vq.push_back('{4'd6,  32'h8000_0000, 32'd31,       32'd1,         1'b0, 8'd32});
    vq.push_back('{4'd10, 32'hFFFF_FFFF, 32'd1,        32'd1,         1'b1, 8'd1});
    vq.push_back('{4'd12, 32'hFFFF_FFFF, 32'd1,        32'd0,         1'b0, 8'd1});
    vq.push_back('{4'd8,  32'h0000_1234, 32'h0000_1234, 32'd1,         1'b1, 8'd1});
    vq.push_back('{4'd9,  32'd3,         32'd3,        32'd0,         1'b0, 8'd1});
    vq.push_back('{4'd11, 32'd1,         32'hFFFF_FFFF, 32'd1,         1'b1, 8'd1});
    vq.push_back('{4'd13, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0, 8'd1});
    vq.push_back('{4'd14, 32'd5,         32'd5,        32'd0,         1'b0, 8'd1});
    vq.push_back('{4'd15, 32'd9,         32'd9,        32'd0,         1'b0, 8'd1});
    foreach (vq[i]) begin
      run_op(vq[i].op, vq[i].a, vq[i].b, r, br, lat, rl);
      checks += 4;
      if (r !== vq[i].r) begin
        errors++;
        $display("FAIL dir[%0d] op=%0d result: got %h want %h", i, vq[i].op, r, vq[i].r);
      end
      if (br !== vq[i].br) begin
        errors++;
        $display("FAIL dir[%0d] op=%0d branch: got %b want %b", i, vq[i].op, br, vq[i].br);
      end
      if (lat != int'(vq[i].lat)) begin
        errors++;
        $display("FAIL dir[%0d] op=%0d latency: got %0d want %0d", i, vq[i].op, lat, vq[i].lat);
      end
      if (rl !== 1'b1) begin
        errors++;
        $display("FAIL dir[%0d] op=%0d ready_low: got %b want 1", i, vq[i].op, rl);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, er;
    logic [3:0]  op;
    logic        br, ebr, rl;
    int          lat, elat;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      model(op, a, b, er, ebr, elat);
      run_op(op, a, b, r, br, lat, rl);
      checks += 3;
      if (r !== er) begin
        errors++;
        $display("FAIL rnd[%0d] op=%0d a=%h b=%h result: got %h want %h", i, op, a, b, r, er);
      end
      if (br !== ebr) begin
        errors++;
        $display("FAIL rnd[%0d] op=%0d a=%h b=%h branch: got %b want %b", i, op, a, b, br, ebr);
      end
      if (lat != elat || rl !== 1'b1) begin
        errors++;
        $display("FAIL rnd[%0d] op=%0d latency/ready: got %0d/%b want %0d/1", i, op, lat, rl, elat);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   lat = 0;
    logic seen = 1'b0;
    logic rdy_early = 1'b0;
    @(negedge clk);
    valid_in = 1'b1;
    ALU_ctr  = 4'd6;
    src_a    = 32'hF000_0000;
    src_b    = 32'd10;
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (valid_out) begin
        seen = 1'b1;
        break;
      end
      if (ready_out) rdy_early = 1'b1;
      ALU_ctr = 4'($urandom);
      src_a   = $urandom;
      src_b   = $urandom;
    end
    checks += 2;
    if (!seen || lat != 11 || rdy_early) begin
      errors++;
      $display("FAIL hold_latency: seen=%b lat=%0d ready_early=%b, want 1 11 0", seen, lat, rdy_early);
    end
    if (result !== 32'h003C_0000 || branch_taken !== 1'b0) begin
      errors++;
      $display("FAIL hold_result: got %h/%b want 003c0000/0", result, branch_taken);
    end
    ALU_ctr = 4'd0;
    src_a   = 32'd2;
    src_b   = 32'd3;
    @(negedge clk);
    checks++;
    if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle: ready=%b valid=%b want 1 0", ready_out, valid_out);
    end
    @(negedge clk);
    valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b1 || result !== 32'd5) begin
      errors++;
      $display("FAIL hold_next_op: valid=%b result=%h want 1 00000005", valid_out, result);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] r;
    logic        br, rl;
    logic        spurious = 1'b0;
    int          lat;
    @(negedge clk);
    valid_in = 1'b1;
    ALU_ctr  = 4'd5;
    src_a    = 32'd1;
    src_b    = 32'd10;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    // Five shift edges take the count from 10 down to 5.
    repeat (5) begin
      @(negedge clk);
      if (valid_out) spurious = 1'b1;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (ready_out !== 1'b1 || valid_out !== 1'b0 || result !== '0 || branch_taken !== 1'b0) begin
      errors++;
      $display("FAIL midshift_reset: ready=%b valid=%b result=%h br=%b want 1 0 0 0",
               ready_out, valid_out, result, branch_taken);
    end
    repeat (12) begin
      @(negedge clk);
      if (valid_out) spurious = 1'b1;
    end
    checks++;
    if (spurious) begin
      errors++;
      $display("FAIL midshift_no_valid: got valid_out pulse, want none");
    end
    run_op(4'd0, 32'd2, 32'd3, r, br, lat, rl);
    checks++;
    if (r !== 32'd5 || br !== 1'b0 || lat != 1) begin
      errors++;
      $display("FAIL post_reset_add: got %h/%b lat %0d want 00000005/0 lat 1", r, br, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
